// File: rtl/uv_spi_txq.sv
// uv_spi_txq: show-ahead TX word queue for the SPI master with level, sticky ovf/udf flags.
// Define UV_SPI_TXQ_WM_EN to build the registered watermark interrupt (otherwise wm_irq is tied low).
module uv_spi_txq #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push_vld,
  input  logic [31:0]   push_dat,
  output logic          push_rdy,
  output logic          tx_rdy,
  input  logic          tx_vld,
  output logic [31:0]   tx_dat,
  output logic [AW:0]   level,
  input  logic [AW:0]   wm_lvl,
  output logic          wm_irq,
  output logic          ovf,
  output logic          udf
);
  logic [31:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, do_push, do_pop;
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty    = wr_ptr == rd_ptr;
  assign do_push  = push_vld && !full;
  assign do_pop   = tx_vld && !empty;
  assign push_rdy = !full;
  assign tx_rdy   = !empty;
  assign level    = wr_ptr - rd_ptr;
  assign tx_dat   = empty ? 32'h0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_vld && full) ovf <= 1'b1;
      if (tx_vld && empty) udf <= 1'b1;
    end
  // storage carries no reset; empty forces tx_dat to zero instead
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_dat;
`ifdef UV_SPI_TXQ_WM_EN
  logic [AW:0] level_next;
  assign level_next = level + (AW+1)'(do_push) - (AW+1)'(do_pop);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wm_irq <= 1'b0;
    else wm_irq <= !flush && (level_next <= wm_lvl);
`else
  logic unused_wm;
  assign unused_wm = ^wm_lvl;
  assign wm_irq    = 1'b0;
`endif
endmodule

// File: tb/tb_uv_spi_txq.sv
// tb_uv_spi_txq: scoreboard bench for uv_spi_txq (DEPTH=8); watermark checks follow UV_SPI_TXQ_WM_EN.
module tb_uv_spi_txq;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, push_vld = 1'b0, tx_vld = 1'b0;
  logic [31:0] push_dat = '0;
  logic [3:0]  wm_lvl = '0;
  logic        push_rdy, tx_rdy, wm_irq, ovf, udf;
  logic [31:0] tx_dat;
  logic [3:0]  level;
  logic [31:0] q[$];
  logic [31:0] exp_d;
  int          n_chk = 0, n_fail = 0;
`ifdef UV_SPI_TXQ_WM_EN
  localparam logic WM = 1'b1;
`else
  localparam logic WM = 1'b0;
`endif

  uv_spi_txq #(.DEPTH(8), .AW(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .push_vld(push_vld), .push_dat(push_dat),
    .push_rdy(push_rdy), .tx_rdy(tx_rdy), .tx_vld(tx_vld), .tx_dat(tx_dat), .level(level),
    .wm_lvl(wm_lvl), .wm_irq(wm_irq), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    push_vld = 1'b1;
    push_dat = d;
    tick();
    push_vld = 1'b0;
    if (q.size() < 8) q.push_back(d);
  endtask

  task automatic pop;
    exp_d = q.pop_front();
    n_chk++;
    if (tx_rdy !== 1'b1 || tx_dat !== exp_d) begin
      n_fail++;
      $display("FAIL pop_head: tx_rdy=%b tx_dat=%h, want 1 %h", tx_rdy, tx_dat, exp_d);
    end
    tx_vld = 1'b1;
    tick();
    tx_vld = 1'b0;
  endtask

  task automatic do_flush;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    q.delete();
  endtask

  task automatic test_reset;
    n_chk++;
    if ({push_rdy, tx_rdy, tx_dat, level, ovf, udf, wm_irq} !== {1'b1, 1'b0, 32'h0, 4'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset: rdy=%b txr=%b dat=%h lvl=%0d ovf=%b udf=%b wm=%b", push_rdy, tx_rdy, tx_dat, level, ovf, udf, wm_irq);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    push(32'hA5A5_0001);
    n_chk++;
    if (tx_rdy !== 1'b1 || tx_dat !== 32'hA5A5_0001 || level !== 4'd1) begin
      n_fail++;
      $display("FAIL single_push: txr=%b dat=%h lvl=%0d, want 1 a5a50001 1", tx_rdy, tx_dat, level);
    end
    pop();
    n_chk++;
    if (tx_rdy !== 1'b0 || tx_dat !== 32'h0 || level !== 4'd0) begin
      n_fail++;
      $display("FAIL single_pop: txr=%b dat=%h lvl=%0d, want 0 0 0", tx_rdy, tx_dat, level);
    end
  endtask

  task automatic test_full_ovf;
    for (int i = 1; i <= 8; i++) push(i);
    n_chk++;
    if (push_rdy !== 1'b0 || level !== 4'd8 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL full: push_rdy=%b lvl=%0d ovf=%b, want 0 8 0", push_rdy, level, ovf);
    end
    push(9);
    n_chk++;
    if (ovf !== 1'b1 || level !== 4'd8) begin
      n_fail++;
      $display("FAIL overflow: ovf=%b lvl=%0d, want 1 8", ovf, level);
    end
    for (int i = 0; i < 8; i++) pop();
    n_chk++;
    if (tx_rdy !== 1'b0 || level !== 4'd0 || ovf !== 1'b1 || udf !== 1'b0) begin
      n_fail++;
      $display("FAIL drained: txr=%b lvl=%0d ovf=%b udf=%b, want 0 0 1 0", tx_rdy, level, ovf, udf);
    end
    do_flush();
  endtask

  task automatic test_simul;
    for (int i = 1; i <= 8; i++) push(i);
    push_vld = 1'b1;
    push_dat = 32'h100;
    tx_vld   = 1'b1;
    tick();
    push_vld = 1'b0;
    tx_vld   = 1'b0;
    void'(q.pop_front());
    n_chk++;
    if (level !== 4'd7 || ovf !== 1'b1 || tx_dat !== 32'd2) begin
      n_fail++;
      $display("FAIL simul_full: lvl=%0d ovf=%b head=%h, want 7 1 2", level, ovf, tx_dat);
    end
    do_flush();
    push_vld = 1'b1;
    push_dat = 32'h55;
    tx_vld   = 1'b1;
    tick();
    push_vld = 1'b0;
    tx_vld   = 1'b0;
    n_chk++;
    if (level !== 4'd1 || udf !== 1'b1 || ovf !== 1'b0 || tx_dat !== 32'h55) begin
      n_fail++;
      $display("FAIL simul_empty: lvl=%0d udf=%b ovf=%b head=%h, want 1 1 0 55", level, udf, ovf, tx_dat);
    end
    do_flush();
  endtask

  task automatic test_stream;
    int sent = 0, got = 0, cyc = 0;
    while ((sent < 20 || got < 20) && cyc < 300) begin
      cyc++;
      push_vld = sent < 20 && q.size() < 8;
      push_dat = 32'hC000_0000 + sent;
      tx_vld   = (cyc % 3 == 0) && q.size() > 0;
      if (tx_vld) begin
        exp_d = q[0];
        n_chk++;
        if (tx_dat !== exp_d) begin
          n_fail++;
          $display("FAIL stream_order: tx_dat=%h, want %h", tx_dat, exp_d);
        end
      end
      tick();
      if (tx_vld) begin
        void'(q.pop_front());
        got++;
      end
      if (push_vld) begin
        q.push_back(push_dat);
        sent++;
      end
      push_vld = 1'b0;
      tx_vld   = 1'b0;
      n_chk++;
      if (ovf !== 1'b0 || udf !== 1'b0 || level !== 4'(q.size())) begin
        n_fail++;
        $display("FAIL stream_state: ovf=%b udf=%b lvl=%0d, want 0 0 %0d", ovf, udf, level, q.size());
      end
    end
    n_chk++;
    if (got != 20) begin
      n_fail++;
      $display("FAIL stream_timeout: got %0d words, want 20", got);
    end
  endtask

  task automatic test_flush;
    tx_vld = 1'b1;
    tick();
    tx_vld = 1'b0;
    for (int i = 0; i < 5; i++) push(32'hF0 + i);
    n_chk++;
    if (udf !== 1'b1 || level !== 4'd5) begin
      n_fail++;
      $display("FAIL flush_setup: udf=%b lvl=%0d, want 1 5", udf, level);
    end
    flush    = 1'b1;
    push_vld = 1'b1;
    push_dat = 32'hDEAD;
    tick();
    flush    = 1'b0;
    push_vld = 1'b0;
    q.delete();
    n_chk++;
    if (level !== 4'd0 || tx_rdy !== 1'b0 || ovf !== 1'b0 || udf !== 1'b0 || wm_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL flush: lvl=%0d txr=%b ovf=%b udf=%b wm=%b, want 0 0 0 0 0", level, tx_rdy, ovf, udf, wm_irq);
    end
    push(32'h77);
    pop();
  endtask

  task automatic test_wm;
    wm_lvl = 4'd2;
    do_flush();
    for (int i = 0; i < 4; i++) push(i);
    n_chk++;
    if (level !== 4'd4 || wm_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL wm_lvl4: lvl=%0d wm=%b, want 4 0", level, wm_irq);
    end
    pop();
    n_chk++;
    if (level !== 4'd3 || wm_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL wm_lvl3: lvl=%0d wm=%b, want 3 0", level, wm_irq);
    end
    pop();
    n_chk++;
    if (level !== 4'd2 || wm_irq !== WM) begin
      n_fail++;
      $display("FAIL wm_assert: lvl=%0d wm=%b, want 2 %b", level, wm_irq, WM);
    end
    push(32'h99);
    n_chk++;
    if (level !== 4'd3 || wm_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL wm_deassert: lvl=%0d wm=%b, want 3 0", level, wm_irq);
    end
    do_flush();
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 3; i++) push(i);
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (tx_rdy !== 1'b0 || level !== 4'd0 || tx_dat !== 32'h0 || push_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: txr=%b lvl=%0d dat=%h rdy=%b, want 0 0 0 1", tx_rdy, level, tx_dat, push_rdy);
    end
    q.delete();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #12;
    test_reset();
    test_single();
    test_full_ovf();
    test_simul();
    test_stream();
    test_flush();
    test_wm();
    test_async_reset();
    test_single();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
